// File: rtl/pc_branch_unit_pkg.sv
// pc_branch_unit_pkg: core state codes, PC mux encodings and NZP bit indices
package pc_branch_unit_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } core_state_t;
  localparam logic [1:0] PCMUX_SEQ   = 2'b00;
  localparam logic [1:0] PCMUX_BRNZP = 2'b01;
  localparam logic [1:0] PCMUX_CALL  = 2'b10;
  localparam logic [1:0] PCMUX_RET   = 2'b11;
  localparam int NZP_P = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_N = 0;
endpackage

// File: rtl/pc_branch_unit_ret_addr_stack.sv
// ret_addr_stack: LIFO of return addresses; push ignored when full, pop ignored when empty
module ret_addr_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [SW-1:0] sp, top;
  assign top = sp - 1'b1;
  assign full = sp == SW'(DEPTH);
  assign empty = sp == '0;
  assign dout = mem[top[AW-1:0]];
  always_ff @(posedge clock or negedge reset)
    if (!reset) sp <= '0;
    else if (push && !full) sp <= sp + 1'b1;
    else if (pop && !empty) sp <= top;
  always_ff @(posedge clock)
    if (push && !full) mem[sp[AW-1:0]] <= din;
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: NZP register, BRnzp resolution and registered next-PC with CALL/RET stack
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [2:0]          core_state,
  input  logic [PC_WIDTH-1:0] current_pc,
  input  logic [PC_WIDTH-1:0] decoded_immediate,
  input  logic [2:0]          decoded_nzp,
  input  logic [1:0]          decoded_pc_mux,
  input  logic                decoded_nzp_write_enable,
  input  logic [2:0]          alu_nzp,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic [2:0]          nzp_reg,
  output logic                branch_taken,
  output logic                stack_error
);
  logic exec, upd, is_call, is_ret, push, pop, full, empty, cond, taken, err;
  logic [PC_WIDTH-1:0] seq, top, npc;
  assign exec = enable && core_state == S_EXECUTE;
  assign upd = enable && core_state == S_UPDATE;
  assign is_call = decoded_pc_mux == PCMUX_CALL;
  assign is_ret = decoded_pc_mux == PCMUX_RET;
  assign push = exec && is_call && !full;
  assign pop = exec && is_ret && !empty;
  assign seq = current_pc + 1'b1;
  assign cond = |(nzp_reg & decoded_nzp);
  always_comb begin
    taken = decoded_pc_mux == PCMUX_BRNZP ? cond : is_call || (is_ret && !empty);
    npc = !taken ? seq : is_ret ? top : decoded_immediate;
    err = (is_call && full) || (is_ret && empty);
  end
  ret_addr_stack #(.WIDTH(PC_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(seq),
    .dout(top),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      next_pc <= '0;
      nzp_reg <= '0;
      branch_taken <= 1'b0;
      stack_error <= 1'b0;
    end else if (exec) begin
      next_pc <= npc;
      branch_taken <= taken;
      if (err) stack_error <= 1'b1;
    end else if (upd) begin
      branch_taken <= 1'b0;
      if (decoded_nzp_write_enable) nzp_reg <= alu_nzp;
    end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed stimulus checked against a behavioural model plus literal expectations
module tb_pc_branch_unit;
  localparam logic [2:0] EX = 3'b101, UP = 3'b110, ID = 3'b000;
  localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, CALL = 2'b10, RET = 2'b11;
  logic clock = 0, reset = 1, enable = 0, we = 0;
  logic [2:0] core_state = ID, decoded_nzp = 0, alu_nzp = 0, nzp_reg;
  logic [1:0] decoded_pc_mux = 0;
  logic [7:0] current_pc = 0, decoded_immediate = 0, next_pc;
  logic branch_taken, stack_error, chk_en = 0;
  int checks = 0, failures = 0;
  logic [7:0] m_pc, m_stk [0:7];
  logic [2:0] m_nzp;
  logic m_bt, m_err;
  int m_sp;
  pc_branch_unit dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .core_state(core_state),
    .current_pc(current_pc),
    .decoded_immediate(decoded_immediate),
    .decoded_nzp(decoded_nzp),
    .decoded_pc_mux(decoded_pc_mux),
    .decoded_nzp_write_enable(we),
    .alu_nzp(alu_nzp),
    .next_pc(next_pc),
    .nzp_reg(nzp_reg),
    .branch_taken(branch_taken),
    .stack_error(stack_error)
  );
  always #5 clock = ~clock;
  always @(posedge clock or negedge reset)
    if (!reset) begin
      m_pc <= 0; m_nzp <= 0; m_bt <= 0; m_err <= 0; m_sp <= 0;
    end else if (enable && core_state == EX) begin
      if (decoded_pc_mux == SEQ || (decoded_pc_mux == BR && (m_nzp & decoded_nzp) == 0)) begin
        m_pc <= current_pc + 8'd1; m_bt <= 0;
      end else if (decoded_pc_mux == BR) begin
        m_pc <= decoded_immediate; m_bt <= 1;
      end else if (decoded_pc_mux == CALL) begin
        m_pc <= decoded_immediate; m_bt <= 1;
        if (m_sp < 4) begin m_stk[m_sp] <= current_pc + 8'd1; m_sp <= m_sp + 1; end
        else m_err <= 1;
      end else if (m_sp > 0) begin
        m_pc <= m_stk[m_sp-1]; m_sp <= m_sp - 1; m_bt <= 1;
      end else begin
        m_pc <= current_pc + 8'd1; m_bt <= 0; m_err <= 1;
      end
    end else if (enable && core_state == UP) begin
      m_bt <= 0;
      if (we) m_nzp <= alu_nzp;
    end
  always @(negedge clock)
    if (chk_en && reset) begin
      checks++;
      if (next_pc !== m_pc || nzp_reg !== m_nzp || branch_taken !== m_bt || stack_error !== m_err) begin
        failures++;
        $display("FAIL model t=%0t got pc=%0d nzp=%b bt=%b err=%b want pc=%0d nzp=%b bt=%b err=%b",
                 $time, next_pc, nzp_reg, branch_taken, stack_error, m_pc, m_nzp, m_bt, m_err);
      end
    end
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask
  task automatic step(input logic [2:0] st, input logic [1:0] mux, input logic [7:0] pc, imm,
                      input logic [2:0] msk, input logic w, input logic [2:0] alu);
    core_state = st; decoded_pc_mux = mux; current_pc = pc; decoded_immediate = imm;
    decoded_nzp = msk; we = w; alu_nzp = alu;
    @(posedge clock); #1;
  endtask
  task automatic ex(input logic [1:0] mux, input logic [7:0] pc, imm, input logic [2:0] msk);
    step(EX, mux, pc, imm, msk, 1'b0, 3'b000);
  endtask
  task automatic upd();
    step(UP, SEQ, 8'd0, 8'd0, 3'b000, 1'b0, 3'b000);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    #2 reset = 0;
    #10 reset = 1; chk_en = 1; enable = 1;
    ex(CALL, 8'd9, 8'd77, 3'b111);
    upd();
    ex(RET, 8'd33, 8'd5, 3'b111);
    ex(RET, 8'd33, 8'd5, 3'b111);
    step(UP, RET, 8'd200, 8'd201, 3'b111, 1'b1, 3'b111);
    chk("pre_reset_err", {7'd0, stack_error}, 8'd1);
    #2 reset = 0;
    #1;
    chk("rst_pc", next_pc, 8'd0);
    chk("rst_nzp", {5'd0, nzp_reg}, 8'd0);
    chk("rst_err", {7'd0, stack_error}, 8'd0);
    chk("rst_bt", {7'd0, branch_taken}, 8'd0);
    @(negedge clock); #2 reset = 1;
    step(UP, SEQ, 8'd0, 8'd0, 3'b000, 1'b1, 3'b001);
    chk("cmp_capture", {5'd0, nzp_reg}, 8'd1);
    step(EX, SEQ, 8'd3, 8'd0, 3'b000, 1'b1, 3'b100);
    chk("cmp_exec_ignored", {5'd0, nzp_reg}, 8'd1);
    chk("seq_pc", next_pc, 8'd4);
    step(UP, SEQ, 8'd3, 8'd0, 3'b000, 1'b0, 3'b100);
    chk("cmp_we0_ignored", {5'd0, nzp_reg}, 8'd1);
    ex(BR, 8'd10, 8'd40, 3'b100);
    chk("br_not_taken_pc", next_pc, 8'd11);
    chk("br_not_taken_bt", {7'd0, branch_taken}, 8'd0);
    upd();
    ex(BR, 8'd10, 8'd40, 3'b011);
    chk("br_taken_pc", next_pc, 8'd40);
    chk("br_taken_bt", {7'd0, branch_taken}, 8'd1);
    upd();
    chk("bt_cleared", {7'd0, branch_taken}, 8'd0);
    ex(BR, 8'd10, 8'd40, 3'b000);
    chk("br_mask0", next_pc, 8'd11);
    upd();
    ex(SEQ, 8'd255, 8'd0, 3'b000);
    chk("wrap", next_pc, 8'd0);
    upd();
    ex(CALL, 8'd7, 8'd50, 3'b000);
    chk("call_pc", next_pc, 8'd50);
    upd();
    ex(RET, 8'd52, 8'd0, 3'b000);
    chk("ret_pc", next_pc, 8'd8);
    chk("ret_bt", {7'd0, branch_taken}, 8'd1);
    upd();
    for (int i = 0; i < 4; i++) begin
      ex(CALL, 8'(11 + 10 * i), 8'(100 + i), 3'b000);
      upd();
    end
    for (int i = 0; i < 4; i++) begin
      ex(RET, 8'd150, 8'd0, 3'b000);
      chk("nested_ret", next_pc, 8'(42 - 10 * i));
      upd();
    end
    chk("nested_err", {7'd0, stack_error}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      ex(CALL, 8'(60 + i), 8'(120 + i), 3'b000);
      upd();
    end
    ex(CALL, 8'd70, 8'd90, 3'b000);
    chk("ovf_pc", next_pc, 8'd90);
    chk("ovf_err", {7'd0, stack_error}, 8'd1);
    upd();
    for (int i = 0; i < 4; i++) begin
      ex(RET, 8'd150, 8'd0, 3'b000);
      chk("ovf_ret", next_pc, 8'(64 - i));
      upd();
    end
    ex(RET, 8'd20, 8'd0, 3'b000);
    chk("unf_pc", next_pc, 8'd21);
    chk("unf_bt", {7'd0, branch_taken}, 8'd0);
    chk("unf_err", {7'd0, stack_error}, 8'd1);
    upd();
    enable = 0;
    ex(SEQ, 8'd100, 8'd0, 3'b000);
    chk("disabled_hold", next_pc, 8'd21);
    enable = 1;
    step(ID, CALL, 8'd100, 8'd33, 3'b111, 1'b1, 3'b010);
    chk("idle_hold_pc", next_pc, 8'd21);
    chk("idle_hold_nzp", {5'd0, nzp_reg}, 8'd1);
    ex(SEQ, 8'd100, 8'd0, 3'b000);
    chk("resume_pc", next_pc, 8'd101);
    upd();
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
